// File: rtl/acc_share_arb.sv
// Round-robin arbiter that shares one signed accumulator between two burst requesters.
// Define ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module acc_share_arb #(
  parameter int unsigned DW      = 10,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned CW      = 4,
  parameter int unsigned MAX_LEN = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_vld,
  output logic                    req0_rdy,
  input  logic signed [DW:0]      req0_data,
  input  logic                    req0_last,
  input  logic                    req1_vld,
  output logic                    req1_rdy,
  input  logic signed [DW:0]      req1_data,
  input  logic                    req1_last,
  output logic                    res_vld,
  input  logic                    res_rdy,
  output logic signed [ACC_W-1:0] res_data,
  output logic                    res_id,
  output logic [CW-1:0]           res_len,
  output logic                    res_ovf,
  output logic                    res_trunc
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CW-1:0]           MaxLen = CW'(MAX_LEN);

  state_e                  state;
  logic                    ptr;
  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           cnt;
  logic                    ovf;

  logic                    grant_id;
  logic                    beat;
  logic signed [DW:0]      bdata;
  logic                    blast;
  logic [ACC_W:0]          sum_wide;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [CW-1:0]           cnt_nxt;
  logic                    hit_max;

  always_comb begin
    grant_id = (req0_vld && req1_vld) ? ptr : req1_vld;
    bdata    = res_id ? req1_data : req0_data;
    blast    = res_id ? req1_last : req0_last;
    // rdy is only ever high for the granted requester while accumulating
    beat     = (req0_vld && req0_rdy) || (req1_vld && req1_rdy);
    // One guard bit: overflow iff the two top bits of the widened sum disagree
    sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-DW){bdata[DW]}}, bdata};
    sum_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
`ifdef ACC_SAT_EN
    if (sum_ovf) begin
      acc_nxt = sum_wide[ACC_W] ? AccMin : AccMax;
    end else begin
      acc_nxt = sum_wide[ACC_W-1:0];
    end
`else
    acc_nxt  = sum_wide[ACC_W-1:0];
`endif
    cnt_nxt  = cnt + CW'(1);
    hit_max  = cnt_nxt == MaxLen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      ptr       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      req0_rdy  <= 1'b0;
      req1_rdy  <= 1'b0;
      res_vld   <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_len   <= '0;
      res_ovf   <= 1'b0;
      res_trunc <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req0_vld || req1_vld) begin
            state     <= StAcc;
            res_id    <= grant_id;
            req0_rdy  <= !grant_id;
            req1_rdy  <= grant_id;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_ovf   <= 1'b0;
            res_trunc <= 1'b0;
          end
        end
        StAcc: begin
          if (beat) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf | sum_ovf;
            if (blast || hit_max) begin
              state     <= StDone;
              req0_rdy  <= 1'b0;
              req1_rdy  <= 1'b0;
              res_vld   <= 1'b1;
              res_data  <= acc_nxt;
              res_len   <= cnt_nxt;
              res_ovf   <= ovf | sum_ovf;
              // last wins when it coincides with the length limit
              res_trunc <= !blast;
            end
          end
        end
        StDone: begin
          if (res_rdy) begin
            res_vld <= 1'b0;
            ptr     <= ~res_id;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_share_arb.sv
// Self-checking bench for acc_share_arb: directed burst table, fairness, backpressure/reset,
// then randomized streams checked against a queue-based behavioural model.
module tb_acc_share_arb;
  localparam int DW      = 10;
  localparam int ACC_W   = 12;
  localparam int CW      = 4;
  localparam int MAX_LEN = 4;
  localparam int MAXV    = 2 ** (ACC_W - 1) - 1;
  localparam int MINV    = -(2 ** (ACC_W - 1));
`ifdef ACC_SAT_EN
  localparam int E3 = 2047;
  localparam int E4 = -2048;
  localparam int E8 = 2046;
`else
  localparam int E3 = -1027;
  localparam int E4 = 1024;
  localparam int E8 = -1028;
`endif

  typedef logic signed [DW:0] op_t;
  typedef struct {op_t d; logic l;} beat_t;
  typedef struct {logic id; int data; int len; logic ovf; logic trunc;} res_t;
  typedef struct {logic id; int n; int d[4]; int lm; int ed; int el; logic eo; logic et;} vec_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    req0_vld, req0_rdy, req0_last;
  logic                    req1_vld, req1_rdy, req1_last;
  op_t                     req0_data, req1_data;
  logic                    res_vld, res_rdy, res_id, res_ovf, res_trunc;
  logic signed [ACC_W-1:0] res_data;
  logic [CW-1:0]           res_len;

  int    checks = 0;
  int    errors = 0;
  logic  mptr;
  beat_t q0[$];
  beat_t q1[$];
  res_t  expq[$];
  vec_t  tbl[9];

  acc_share_arb #(.DW(DW), .ACC_W(ACC_W), .CW(CW), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_data(req0_data), .req0_last(req0_last),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_data(req1_data), .req1_last(req1_last),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data), .res_id(res_id),
    .res_len(res_len), .res_ovf(res_ovf), .res_trunc(res_trunc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input int data, input int len, input logic ovf,
                          input logic trunc);
    res_t r;
    r.id = id; r.data = data; r.len = len; r.ovf = ovf; r.trunc = trunc;
    expq.push_back(r);
  endtask

  task automatic push_beat(input logic id, input int d, input logic l);
    beat_t b;
    b.d = op_t'(d);
    b.l = l;
    if (id) q1.push_back(b);
    else q0.push_back(b);
  endtask

  task automatic set_row(input int i, input logic id, input int n, input int d0, input int d1,
                         input int d2, input int d3, input int lm, input int ed, input int el,
                         input logic eo, input logic et);
    tbl[i].id = id; tbl[i].n = n;
    tbl[i].d[0] = d0; tbl[i].d[1] = d1; tbl[i].d[2] = d2; tbl[i].d[3] = d3;
    tbl[i].lm = lm; tbl[i].ed = ed; tbl[i].el = el; tbl[i].eo = eo; tbl[i].et = et;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_res_vld"}, res_vld, 0);
    chk({nm, "_res_data"}, res_data, 0);
    chk({nm, "_res_id"}, res_id, 0);
    chk({nm, "_res_len"}, res_len, 0);
    chk({nm, "_res_ovf"}, res_ovf, 0);
    chk({nm, "_res_trunc"}, res_trunc, 0);
    chk({nm, "_req0_rdy"}, req0_rdy, 0);
    chk({nm, "_req1_rdy"}, req1_rdy, 0);
  endtask

  // Reference: each grant consumes beats from one stream until last or MAX_LEN beats.
  task automatic build_expected();
    beat_t c0[$];
    beat_t c1[$];
    beat_t b;
    logic  id, ov, done;
    int    s, n;
    c0 = q0;
    c1 = q1;
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) id = mptr;
      else id = (c0.size() > 0) ? 1'b0 : 1'b1;
      s = 0; n = 0; ov = 1'b0; done = 1'b0;
      while (!done) begin
        b = id ? c1.pop_front() : c0.pop_front();
        s += int'(b.d);
        n++;
        if (s > MAXV || s < MINV) begin
          ov = 1'b1;
`ifdef ACC_SAT_EN
          s = (s > MAXV) ? MAXV : MINV;
`else
          s = (s > MAXV) ? s - 2 ** ACC_W : s + 2 ** ACC_W;
`endif
        end
        if (b.l || n == MAX_LEN) done = 1'b1;
      end
      push_exp(id, s, n, ov, !b.l);
      mptr = !id;
    end
  endtask

  // Streams beats from q0/q1, randomly stalling the granted requester and the consumer.
  task automatic run_engine(input int gap_pct, input int hold_pct, input int budget);
    int   cyc;
    logic a0, a1, lt, h;
    res_t e;
    cyc = 0;
    while (expq.size() > 0 && cyc < budget) begin
      req0_vld = (q0.size() > 0) && !(req0_rdy && ($urandom_range(99) < gap_pct));
      req1_vld = (q1.size() > 0) && !(req1_rdy && ($urandom_range(99) < gap_pct));
      if (q0.size() > 0) begin req0_data = q0[0].d; req0_last = q0[0].l; end
      if (q1.size() > 0) begin req1_data = q1[0].d; req1_last = q1[0].l; end
      res_rdy = $urandom_range(99) >= hold_pct;
      a0 = req0_vld && req0_rdy;
      a1 = req1_vld && req1_rdy;
      lt = (a0 && req0_last) || (a1 && req1_last);
      h  = res_vld && res_rdy;
      if (h) begin
        e = expq.pop_front();
        chk("res_id", res_id, e.id);
        chk("res_data", res_data, e.data);
        chk("res_len", res_len, e.len);
        chk("res_ovf", res_ovf, e.ovf);
        chk("res_trunc", res_trunc, e.trunc);
      end
      if (res_vld) chk("rdy_in_done", int'(req0_rdy) + int'(req1_rdy), 0);
      if (req0_rdy && req1_rdy) chk("rdy_both", 1, 0);
      tick();
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      if (lt) chk("vld_after_last", res_vld, 1);
      cyc++;
    end
    if (expq.size() > 0) begin
      chk("engine_timeout", expq.size(), 0);
      expq.delete();
    end
    req0_vld = 1'b0; req1_vld = 1'b0; res_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = 1'b0;
  endtask

  initial begin
    int r, n, v;
    rst = 1'b1;
    req0_vld = 0; req0_data = '0; req0_last = 0;
    req1_vld = 0; req1_data = '0; req1_last = 0;
    res_rdy = 0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    mptr = 1'b0;

    // Directed bursts: {id, beats, data, last mask, expected data/len/ovf/trunc}
    set_row(0, 0, 1, 5, 0, 0, 0, 'b0001, 5, 1, 0, 0);
    set_row(1, 1, 4, 1, 1, 1, 1, 'b0000, 4, 4, 0, 1);
    set_row(2, 1, 2, 1, 1, 0, 0, 'b0010, 2, 2, 0, 0);
    set_row(3, 0, 3, 1023, 1023, 1023, 0, 'b0100, E3, 3, 1, 0);
    set_row(4, 1, 3, -1024, -1024, -1024, 0, 'b0100, E4, 3, 1, 0);
    set_row(5, 0, 4, 2, -3, 4, -5, 'b1000, -2, 4, 0, 0);
    set_row(6, 1, 2, 1023, 1023, 0, 0, 'b0010, 2046, 2, 0, 0);
    set_row(7, 0, 1, -1, 0, 0, 0, 'b0001, -1, 1, 0, 0);
    set_row(8, 1, 4, 1023, 1023, 1023, -1, 'b1000, E8, 4, 1, 0);
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < tbl[i].n; k++) push_beat(tbl[i].id, tbl[i].d[k], tbl[i].lm[k]);
      push_exp(tbl[i].id, tbl[i].ed, tbl[i].el, tbl[i].eo, tbl[i].et);
      mptr = !tbl[i].id;
      run_engine(0, 0, 200);
    end

    // Fairness from reset with both requesters continuously valid
    do_reset();
    push_beat(0, 3, 0); push_beat(0, -7, 1); push_beat(0, 1, 1);
    push_beat(1, -100, 0); push_beat(1, 40, 1);
    push_exp(0, -4, 2, 0, 0);
    push_exp(1, -60, 2, 0, 0);
    push_exp(0, 1, 1, 0, 0);
    mptr = 1'b1;
    run_engine(0, 0, 200);

    // Backpressure: result held, no new grant while res_rdy is low
    req0_vld = 1; req0_data = op_t'(7); req0_last = 1; res_rdy = 0;
    tick();
    chk("bp_grant_rdy0", req0_rdy, 1);
    tick();
    chk("bp_res_vld", res_vld, 1);
    chk("bp_res_data", res_data, 7);
    chk("bp_res_id", res_id, 0);
    chk("bp_res_len", res_len, 1);
    req0_vld = 0;
    req1_vld = 1; req1_data = op_t'(100); req1_last = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld", res_vld, 1);
      chk("bp_hold_data", res_data, 7);
      chk("bp_no_grant", req1_rdy, 0);
    end
    res_rdy = 1;
    tick();
    res_rdy = 0;
    chk("bp_release", res_vld, 0);

    // Reset mid-burst while req1 holds the grant; pointer must return to 0
    req0_vld = 1; req0_data = op_t'(50); req0_last = 0;
    tick();
    chk("rr_ptr1_rdy1", req1_rdy, 1);
    chk("rr_ptr1_rdy0", req0_rdy, 0);
    repeat (2) tick();
    rst = 1;
    tick();
    chk_all_zero("midrst");
    rst = 0;
    req0_last = 1; req1_last = 1;
    tick();
    chk("ptr_reset_rdy0", req0_rdy, 1);
    tick();
    chk("post_rst_vld", res_vld, 1);
    chk("post_rst_data", res_data, 50);
    chk("post_rst_len", res_len, 1);
    chk("post_rst_id", res_id, 0);
    req0_vld = 0; req1_vld = 0; res_rdy = 1;
    tick();
    res_rdy = 0;
    mptr = 1'b1;

    // Randomized streams; each stream ends with last so the model never runs dry
    for (int rnd = 0; rnd < 25; rnd++) begin
      for (int id = 0; id < 2; id++) begin
        n = $urandom_range(8);
        for (int k = 0; k < n; k++) begin
          r = $urandom_range(3);
          if (r == 0) v = 1023;
          else if (r == 1) v = -1024;
          else v = int'($urandom_range(2047)) - 1024;
          push_beat(id[0], v, (k == n - 1) || ($urandom_range(3) == 0));
        end
      end
      build_expected();
      run_engine(30, 40, 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_share_arb.md
Name: acc_share_arb

Overview:
Arbitrates a shared signed accumulate datapath between two streaming requesters.
- Each requester sends a burst of signed operands.
- The block grants one requester at a time (round-robin), accumulates its burst and returns one result with status flags.
- Sits between operand producers and any consumer of the accumulated sum.

Parameters:
DW, 10, operand magnitude index; operands are signed [DW:0] (DW+1 bits)
ACC_W, 16, accumulator and result width (signed), must be >= DW+1
CW, 4, beat-counter width
MAX_LEN, 15, max beats per burst; must be >= 1 and <= 2**CW-1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req0_vld  input  1  requester 0 operand valid
req0_rdy  output  1  requester 0 operand accepted this cycle when vld&rdy
req0_data  input  signed [DW:0]  requester 0 operand
req0_last  input  1  marks final operand of requester 0 burst
req1_vld  input  1  requester 1 operand valid
req1_rdy  output  1  requester 1 ready
req1_data  input  signed [DW:0]  requester 1 operand
req1_last  input  1  requester 1 last marker
res_vld  output  1  result valid
res_rdy  input  1  consumer ready
res_data  output  signed [ACC_W-1:0]  accumulated sum
res_id  output  1  requester that produced result
res_len  output  [CW-1:0]  number of beats accumulated
res_ovf  output  1  signed overflow occurred during burst (sticky per burst)
res_trunc  output  1  burst ended by MAX_LEN, not by last

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, priority pointer=0.
  - All outputs 0: rdy, res_vld, res_data, res_id, res_len, res_ovf, res_trunc.
  - Accumulator and counter cleared.
  - Reset mid-burst discards the partial sum; no result is emitted.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - If exactly one reqN_vld=1: grant N.
  - If both are valid: grant the requester named by the pointer.
  - On grant: go to ACC; clear acc, count, ovf and trunc; latch res_id=N.
  - No operand is accepted in IDLE, so the first beat is accepted no earlier than the cycle after the grant.
- ACC:
  - reqN_rdy=1 for the granted requester only; the other rdy=0.
  - Per beat (vld&rdy): acc <= acc + sign-extended data (to ACC_W); count <= count+1.
  - If the signed sum overflows ACC_W bits: result wraps modulo 2**ACC_W; ovf <= 1.
  - Granted vld=0: stall, state unchanged, no timeout.
  - Beat with last=1: go to DONE.
  - Beat where count+1 == MAX_LEN and last=0: go to DONE; trunc <= 1.
  - If both conditions hold on the same beat: go to DONE with trunc=0 (last wins).
  - Register outputs (res_data, res_len, res_ovf, res_trunc) are updated on the transition into DONE.
- DONE:
  - res_vld=1; res_data, res_id, res_len, res_ovf and res_trunc are stable while res_vld=1.
  - Both rdy=0.
  - On res_rdy=1: res_vld <= 0, pointer <= ~res_id, go to IDLE.
- Latency: res_vld rises the cycle after the terminating beat is accepted. Minimum IDLE->IDLE round trip is 3 cycles for a 1-beat burst with res_rdy held high.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.

Optional Feature:
ACC_SAT_EN
- Defined: the accumulator saturates on overflow to +(2**(ACC_W-1)-1) or -(2**(ACC_W-1)); res_ovf is still set. Subsequent beats add to the saturated value and saturate again if needed.
- Undefined: two's-complement wrap as specified in Behaviour.

Test Plan:
- Single 1-beat burst: req0 data=+5, last=1 -> res_vld=1 one cycle after accept; res_data=5, res_id=0, res_len=1, res_ovf=0, res_trunc=0.
- Both requesters valid from reset, each sending 2-beat bursts (req0: 3,-7; req1: -100,40) -> first result id=0, data=-4; second id=1, data=-60; third grant goes to 0.
- Truncation: MAX_LEN=4; req1 streams 6 beats of +1, last only on beat 6 -> result data=4, len=4, trunc=1; req1_rdy=0 during DONE.
- Overflow, ACC_W=12, DW=10: three beats of +1023 -> wrap build res_data=-1027, ovf=1; ACC_SAT_EN build res_data=2047, ovf=1.
- Backpressure and reset: hold res_rdy=0 for 5 cycles -> outputs stable, no grant issued; assert rst for 1 cycle mid-ACC -> all outputs 0 next cycle, pointer=0, partial sum discarded.
